// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU; round-robin grant, one op in flight.
// Latency: accept at T, ALU drive at T+1, registered response at T+2; min issue interval 3 cycles.
// Backpressure: response held until resp{owner}_ready; no req_ready outside IDLE. Optional macro: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_zero_q, resp_zero_d;
  logic             grant_vld;
  logic             grant_id;
  logic             owner_resp_rdy;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             ptr_q, ptr_d;
`endif

  // Pick the winner among valid requesters; a lone requester always wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id  = ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      grant_id = ptr_q;
    end else begin
      grant_id = ~req0_valid;
    end
`endif
  end

  assign owner_resp_rdy = owner_q ? resp1_ready : resp0_ready;

  // Next-state, latch enables and handshake outputs for the three-phase transaction.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    resp_data_d = resp_data_q;
    resp_zero_d = resp_zero_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Ready is suppressed during reset so all outputs read zero then.
        if (grant_vld && !rst) begin
          owner_d = grant_id;
          state_d = S_EXEC;
          if (grant_id) begin
            req1_ready = 1'b1;
            alu_a_d    = req1_a;
            alu_b_d    = req1_b;
            alu_op_d   = req1_op;
          end else begin
            req0_ready = 1'b1;
            alu_a_d    = req0_a;
            alu_b_d    = req0_b;
            alu_op_d   = req0_op;
          end
        end
      end
      S_EXEC: begin
        resp_data_d = alu_result;
        resp_zero_d = alu_zero;
        state_d     = S_RESP;
      end
      S_RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if (owner_resp_rdy) begin
          state_d = S_IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d   = ~owner_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      resp_data_q <= resp_data_d;
      resp_zero_q <= resp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign resp_data = resp_data_q;
  assign resp_zero = resp_zero_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table-driven single ops, hand sequences for corner cases,
// and a randomized run against a transaction-level reference model.
// The shared ALU is modelled here as a combinational function of the DUT's alu_* outputs.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  vld = 2'b00;
  logic [1:0]  rdy;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rop [2];
  logic [31:0] alu_a, alu_b, alu_result, resp_data;
  logic [3:0]  alu_op;
  logic        alu_zero, resp_zero, owner;
  logic [1:0]  rvld;
  logic [1:0]  rrdy = 2'b00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_op);
  assign alu_zero   = (alu_result == 32'd0);

  alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(vld[0]), .req0_ready(rdy[0]), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
    .req1_valid(vld[1]), .req1_ready(rdy[1]), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp0_valid(rvld[0]), .resp0_ready(rrdy[0]),
    .resp1_valid(rvld[1]), .resp1_ready(rrdy[1]),
    .resp_data(resp_data), .resp_zero(resp_zero), .owner(owner)
  );

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] r;
    bit          z;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    vld  = 2'b00;
    rrdy = 2'b00;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rb[i] = '0; rop[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {30'd0, rdy}, 32'd0);
    check({tag, "_rvld"}, {30'd0, rvld}, 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
    check({tag, "_data"}, resp_data, 32'd0);
    check({tag, "_zero"}, {31'd0, resp_zero}, 32'd0);
    check({tag, "_owner"}, {31'd0, owner}, 32'd0);
  endtask

  // Full single transaction from an idle arbiter; response consumed at T+2.
  task automatic single_op(input vec_t v);
    vld[v.id] = 1'b1;
    ra[v.id] = v.a; rb[v.id] = v.b; rop[v.id] = v.op;
    settle();
    check("vec_ready_T", {30'd0, rdy}, v.id ? 32'd2 : 32'd1);
    step();
    vld = 2'b00;
    settle();
    check("vec_alu_a", alu_a, v.a);
    check("vec_alu_b", alu_b, v.b);
    check("vec_alu_op", {28'd0, alu_op}, {28'd0, v.op});
    check("vec_rvld_exec", {30'd0, rvld}, 32'd0);
    step();
    settle();
    check("vec_rvld_T2", {30'd0, rvld}, v.id ? 32'd2 : 32'd1);
    check("vec_data", resp_data, v.r);
    check("vec_zero", {31'd0, resp_zero}, {31'd0, v.z});
    check("vec_owner", {31'd0, owner}, {31'd0, v.id});
    rrdy[v.id] = 1'b1;
    step();
    rrdy = 2'b00;
    settle();
    check("vec_rvld_done", {30'd0, rvld}, 32'd0);
  endtask

  initial begin
    int gcyc [$];
    int gid  [$];
    logic [31:0] held;
    // randomized-model state
    bit          m_busy;
    int          m_since;
    bit          m_owner;
    bit          m_ptr;
    logic [31:0] m_data;
    bit          m_zero;
    int          win;

    vecs[0] = '{id: 1'b0, a: 32'd5,         b: 32'd3,         op: OP_ADD, r: 32'd8,         z: 1'b0};
    vecs[1] = '{id: 1'b1, a: 32'd7,         b: 32'd7,         op: OP_SUB, r: 32'd0,         z: 1'b1};
    vecs[2] = '{id: 1'b0, a: 32'h0000F0F0,  b: 32'h00000FF0,  op: OP_AND, r: 32'h000000F0,  z: 1'b0};
    vecs[3] = '{id: 1'b1, a: 32'hF0000000,  b: 32'h0000000F,  op: OP_OR,  r: 32'hF000000F,  z: 1'b0};
    vecs[4] = '{id: 1'b0, a: 32'hFFFFFFFF,  b: 32'd1,         op: OP_ADD, r: 32'd0,         z: 1'b1};
    vecs[5] = '{id: 1'b1, a: 32'hAAAAAAAA,  b: 32'hAAAAAAAA,  op: OP_XOR, r: 32'd0,         z: 1'b1};
    vecs[6] = '{id: 1'b0, a: 32'd3,         b: 32'd5,         op: OP_SUB, r: 32'hFFFFFFFE,  z: 1'b0};

    clear_inputs();
    rst = 1'b1;
    step();
    vld = 2'b11;
    settle();
    check_all_zero("in_reset");
    vld = 2'b00;
    step();
    rst = 1'b0;
    settle();
    check_all_zero("after_reset");

    // Table-driven single operations
    for (int i = 0; i < 7; i++) single_op(vecs[i]);

    // Simultaneous requests, responses consumed immediately
    do_reset();
    vld = 2'b11; rrdy = 2'b11;
    ra[0] = 32'd1; rb[0] = 32'd2; rop[0] = OP_ADD;
    ra[1] = 32'd9; rb[1] = 32'd4; rop[1] = OP_SUB;
    for (int c = 0; c < 12; c++) begin
      settle();
      check("both_not_dual_ready", {31'd0, &rdy}, 32'd0);
      if (rdy[0]) begin gcyc.push_back(c); gid.push_back(0); end
      if (rdy[1]) begin gcyc.push_back(c); gid.push_back(1); end
      step();
    end
    check("grant_count", gcyc.size(), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < gcyc.size()) begin
        check("grant_cycle", gcyc[g], 3 * g);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("grant_id", gid[g], 32'd0);
`else
        check("grant_id", gid[g], g % 2);
`endif
      end
    end

    // Response backpressure
    do_reset();
    vld[0] = 1'b1; ra[0] = 32'd20; rb[0] = 32'd22; rop[0] = OP_ADD;
    settle();
    check("bp_ready0", {31'd0, rdy[0]}, 32'd1);
    step();
    vld[0] = 1'b0;
    vld[1] = 1'b1; ra[1] = 32'd1; rb[1] = 32'd1; rop[1] = OP_ADD;
    settle();
    check("bp_exec_ready1", {31'd0, rdy[1]}, 32'd0);
    step();
    held = 32'd42;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_rvld0", {31'd0, rvld[0]}, 32'd1);
      check("bp_data", resp_data, held);
      check("bp_ready1", {31'd0, rdy[1]}, 32'd0);
      step();
    end
    rrdy[0] = 1'b1;
    settle();
    check("bp_release_rvld0", {31'd0, rvld[0]}, 32'd1);
    check("bp_release_ready1", {31'd0, rdy[1]}, 32'd0);
    step();
    rrdy[0] = 1'b0;
    settle();
    check("bp_accept_ready1", {31'd0, rdy[1]}, 32'd1);
    step();
    vld = 2'b00;

    // Reset in EXEC after pointer has moved to req1
    do_reset();
    single_op(vecs[0]);
    vld[1] = 1'b1; ra[1] = 32'd9; rb[1] = 32'd2; rop[1] = OP_ADD;
    settle();
    check("rst_mid_accept1", {31'd0, rdy[1]}, 32'd1);
    step();
    vld = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check_all_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("rst_mid_no_resp", {30'd0, rvld}, 32'd0);
    end
    vld = 2'b11;
    settle();
    check("rst_mid_dual_grant", {30'd0, rdy}, 32'd1);
    step();
    vld = 2'b00;

    // Withdrawn request while busy
    do_reset();
    vld[0] = 1'b1; ra[0] = 32'd6; rb[0] = 32'd1; rop[0] = OP_SUB;
    settle();
    check("wd_ready0", {31'd0, rdy[0]}, 32'd1);
    step();
    vld = 2'b10;
    settle();
    check("wd_exec_ready1", {31'd0, rdy[1]}, 32'd0);
    step();
    vld = 2'b00;
    settle();
    check("wd_rvld0", {31'd0, rvld[0]}, 32'd1);
    check("wd_data", resp_data, 32'd5);
    rrdy[0] = 1'b1;
    step();
    rrdy = 2'b00;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("wd_idle_ready", {30'd0, rdy}, 32'd0);
      check("wd_idle_rvld", {30'd0, rvld}, 32'd0);
      step();
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    m_busy = 0; m_since = 0; m_owner = 0; m_ptr = 0; m_data = '0; m_zero = 0;
    for (int c = 0; c < 600; c++) begin
      vld  = 2'($urandom_range(0, 3));
      rrdy = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        ra[i]  = $urandom;
        rb[i]  = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
        rop[i] = 4'($urandom_range(0, 5));
      end
      settle();
      win = -1;
      if (!m_busy) begin
        if (vld == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          win = 0;
`else
          win = m_ptr;
`endif
        end else if (vld[0]) win = 0;
        else if (vld[1]) win = 1;
        check("rnd_ready", {30'd0, rdy}, (win < 0) ? 32'd0 : (32'd1 << win));
        check("rnd_rvld_idle", {30'd0, rvld}, 32'd0);
      end else begin
        check("rnd_ready_busy", {30'd0, rdy}, 32'd0);
        if (m_since >= 2) begin
          check("rnd_rvld", {30'd0, rvld}, 32'd1 << m_owner);
          check("rnd_data", resp_data, m_data);
          check("rnd_zero", {31'd0, resp_zero}, {31'd0, m_zero});
          check("rnd_owner", {31'd0, owner}, {31'd0, m_owner});
        end else begin
          check("rnd_rvld_exec", {30'd0, rvld}, 32'd0);
        end
      end
      if (!m_busy && win >= 0) begin
        m_busy  = 1;
        m_since = 1;
        m_owner = win[0];
        m_data  = alu_ref(ra[win], rb[win], rop[win]);
        m_zero  = (m_data == 32'd0);
      end else if (m_busy) begin
        if (m_since >= 2 && rrdy[m_owner]) begin
          m_busy = 0;
          m_ptr  = ~m_owner;
        end else begin
          m_since++;
        end
      end
      step();
    end

    clear_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
